led_display_scheduler: RTL and testbench

- Sequences the LED animator through the game's display phases: attract/idle, in-play fuel gauge, record celebration and game-over.
- Converts the fuel level to the thermometer code the animator's fuel gauge input expects.
- Issues the single-cycle new-personal-best and new-global-best strobes the animator needs.
- Sits between the game-control FSM/score logic and the LED animator; it is the only driver of the animator's mode and strobe inputs.

---
 rtl/led_display_scheduler.sv | 138 +++++++++++++
 tb/tb_led_display_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_display_scheduler.sv
// LED display scheduler: walks the LED animator through attract, in-play fuel
// gauge, record celebration and game-over phases, and drives the animator's
// fuel gauge and record strobes. Every output comes straight from a register.
module led_display_scheduler #(
    parameter int SCORE_W         = 16,
    parameter int CELEB_CYCLES    = 50,
    parameter int GAMEOVER_CYCLES = 100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               game_start,
    input  logic               game_over,
    input  logic [3:0]         fuel_level,
    input  logic [SCORE_W-1:0] final_score,
    input  logic [SCORE_W-1:0] personal_best,
    input  logic [SCORE_W-1:0] global_best,
    output logic [9:0]         fuel_gauge,
    output logic [2:0]         disp_mode,
    output logic               new_personal_best,
    output logic               new_global_best,
    output logic               busy
);

    localparam int MAX_CYCLES = (CELEB_CYCLES > GAMEOVER_CYCLES) ? CELEB_CYCLES : GAMEOVER_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] CELEB_LAST    = CNT_W'(CELEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAMEOVER_LAST = CNT_W'(GAMEOVER_CYCLES - 1);

    // State codes equal the animator mode codes, so disp_mode is the state register.
    typedef enum logic [2:0] {
        ST_PLAY     = 3'b000,
        ST_IDLE     = 3'b001,
        ST_CELEB_P  = 3'b010,
        ST_CELEB_G  = 3'b011,
        ST_GAMEOVER = 3'b100
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       gauge_q, gauge_d;
    logic             npb_q, npb_d;
    logic             ngb_q, ngb_d;
    logic             busy_q, busy_d;

    logic [3:0]       fuel_sat;
    logic [9:0]       therm;

    assign fuel_sat = (fuel_level > 4'd10) ? 4'd10 : fuel_level;

    // Thermometer fills from the MSB down: bit (9-gi) lit when level exceeds gi.
    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_therm
            assign therm[9-gi] = (fuel_sat > 4'(gi));
        end
    endgenerate

    // State register plus all registered outputs; reset also kills pending strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gauge_q <= '0;
            npb_q   <= 1'b0;
            ngb_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gauge_q <= gauge_d;
            npb_q   <= npb_d;
            ngb_q   <= ngb_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and hold-counter logic; game_over wins over game_start in PLAY.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (game_start) begin
                    state_d = ST_PLAY;
                    cnt_d   = '0;
                end
            end
            ST_PLAY: begin
                if (game_over) begin
                    cnt_d = '0;
                    if (final_score > global_best)
                        state_d = ST_CELEB_G;
                    else if (final_score > personal_best)
                        state_d = ST_CELEB_P;
                    else
                        state_d = ST_GAMEOVER;
                end
            end
            ST_CELEB_P, ST_CELEB_G: begin
                if (cnt_q == CELEB_LAST) begin
                    state_d = ST_GAMEOVER;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAMEOVER: begin
                if (game_start) begin
                    state_d = ST_PLAY;
                    cnt_d   = '0;
                end else if (cnt_q == GAMEOVER_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output next-values: strobes fire only on the edge that leaves PLAY for a celebration.
    always_comb begin
        npb_d   = (state_q == ST_PLAY) && ((state_d == ST_CELEB_P) || (state_d == ST_CELEB_G));
        ngb_d   = (state_q == ST_PLAY) && (state_d == ST_CELEB_G);
        gauge_d = (state_d == ST_PLAY) ? therm : 10'd0;
        busy_d  = (state_d != ST_IDLE);
    end

    assign disp_mode         = state_q;
    assign fuel_gauge        = gauge_q;
    assign new_personal_best = npb_q;
    assign new_global_best   = ngb_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_led_display_scheduler.sv
// Testbench for led_display_scheduler: directed scenarios plus random traffic,
// each cycle compared against a phase/countdown reference model.
module tb_led_display_scheduler;

    localparam int C = 6;
    localparam int G = 9;

    localparam logic [2:0] M_PLAY = 3'b000;
    localparam logic [2:0] M_IDLE = 3'b001;
    localparam logic [2:0] M_CP   = 3'b010;
    localparam logic [2:0] M_CG   = 3'b011;
    localparam logic [2:0] M_GO   = 3'b100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        game_start = 1'b0;
    logic        game_over = 1'b0;
    logic [3:0]  fuel_level = 4'd0;
    logic [15:0] final_score = 16'd0;
    logic [15:0] personal_best = 16'd0;
    logic [15:0] global_best = 16'd0;
    logic [9:0]  fuel_gauge;
    logic [2:0]  disp_mode;
    logic        new_personal_best;
    logic        new_global_best;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Reference model: current phase and cycles left in that phase.
    logic [2:0] m_mode = M_IDLE;
    int         m_left = 0;
    logic [9:0] m_gauge = 10'd0;
    logic       m_npb = 1'b0;
    logic       m_ngb = 1'b0;

    logic [15:0] obs;
    logic [15:0] expv;

    led_display_scheduler #(
        .SCORE_W(16),
        .CELEB_CYCLES(C),
        .GAMEOVER_CYCLES(G)
    ) dut (
        .clk(clk),
        .rst(rst),
        .game_start(game_start),
        .game_over(game_over),
        .fuel_level(fuel_level),
        .final_score(final_score),
        .personal_best(personal_best),
        .global_best(global_best),
        .fuel_gauge(fuel_gauge),
        .disp_mode(disp_mode),
        .new_personal_best(new_personal_best),
        .new_global_best(new_global_best),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        int n;
        m_npb = 1'b0;
        m_ngb = 1'b0;
        if (rst) begin
            m_mode = M_IDLE;
            m_left = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (game_start) m_mode = M_PLAY;
                M_PLAY: begin
                    if (game_over) begin
                        if (final_score > global_best) begin
                            m_mode = M_CG; m_npb = 1'b1; m_ngb = 1'b1; m_left = C;
                        end else if (final_score > personal_best) begin
                            m_mode = M_CP; m_npb = 1'b1; m_left = C;
                        end else begin
                            m_mode = M_GO; m_left = G;
                        end
                    end
                end
                M_CP, M_CG: begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_mode = M_GO; m_left = G;
                    end
                end
                M_GO: begin
                    if (game_start) m_mode = M_PLAY;
                    else begin
                        m_left = m_left - 1;
                        if (m_left == 0) m_mode = M_IDLE;
                    end
                end
                default: m_mode = M_IDLE;
            endcase
        end
        n = (fuel_level > 10) ? 10 : int'(fuel_level);
        m_gauge = (m_mode == M_PLAY) ? 10'(((1 << n) - 1) << (10 - n)) : 10'd0;
    endtask

    // One clock: model advances on the edge, outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        obs  = {disp_mode, fuel_gauge, new_personal_best, new_global_best, busy};
        expv = {m_mode, m_gauge, m_npb, m_ngb, (m_mode != M_IDLE)};
    endtask

    task automatic clear_inputs();
        rst = 1'b0; game_start = 1'b0; game_over = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: got %b expected %b", k, obs, expv);
            end
        end
        clear_inputs();
        tick();
        checks++;
        if ({disp_mode, fuel_gauge, new_personal_best, new_global_best, busy} !== {3'b001, 10'd0, 3'b000}) begin
            errors++;
            $display("FAIL reset_values: got mode %b gauge %b npb %b ngb %b busy %b expected 001/0/0/0/0",
                     disp_mode, fuel_gauge, new_personal_best, new_global_best, busy);
        end
        game_start = 1'b1;
        tick();
        game_start = 1'b0;
        checks++;
        if (disp_mode !== 3'b000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_to_play: got mode %b busy %b expected 000 1", disp_mode, busy);
        end
    endtask

    task automatic test_fuel();
        logic [3:0] lv[4];
        logic [9:0] ex[4];
        lv = '{4'd3, 4'd0, 4'd10, 4'd15};
        ex = '{10'b1110000000, 10'b0000000000, 10'b1111111111, 10'b1111111111};
        rst = 1'b1; tick(); clear_inputs();
        game_start = 1'b1; tick(); game_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            fuel_level = lv[k];
            tick();
            checks++;
            if (fuel_gauge !== ex[k]) begin
                errors++;
                $display("FAIL fuel_gauge lvl %0d: got %b expected %b", lv[k], fuel_gauge, ex[k]);
            end
        end
        for (int k = 0; k < 24; k++) begin
            fuel_level = 4'($urandom_range(0, 15));
            game_start = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL fuel_random cyc %0d: got %b expected %b", k, obs, expv);
            end
        end
        game_start = 1'b0;
    endtask

    // Runs a full game ending with the given scores; counts dwell and strobes.
    task automatic run_game(input string name, input logic [15:0] fs, input logic [15:0] pb,
                            input logic [15:0] gb, input logic [2:0] want_mode,
                            input int want_celeb, input int want_npb, input int want_ngb);
        int n_celeb = 0;
        int n_go = 0;
        int n_npb = 0;
        int n_ngb = 0;
        rst = 1'b1; tick(); clear_inputs();
        game_start = 1'b1; tick(); game_start = 1'b0;
        fuel_level = 4'd7; tick();
        final_score = fs; personal_best = pb; global_best = gb;
        game_over = 1'b1;
        for (int k = 0; k < C + G + 4; k++) begin
            tick();
            game_over = 1'b0;
            if (k == 0) begin
                checks++;
                if (disp_mode !== want_mode) begin
                    errors++;
                    $display("FAIL %s entry_mode: got %b expected %b", name, disp_mode, want_mode);
                end
            end
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL %s cyc %0d: got %b expected %b", name, k, obs, expv);
            end
            if (disp_mode == M_CP || disp_mode == M_CG) n_celeb++;
            if (disp_mode == M_GO) n_go++;
            if (new_personal_best) n_npb++;
            if (new_global_best) n_ngb++;
        end
        checks++;
        if (n_celeb != want_celeb || n_go != G || n_npb != want_npb || n_ngb != want_ngb || disp_mode !== M_IDLE) begin
            errors++;
            $display("FAIL %s dwell: got celeb %0d go %0d npb %0d ngb %0d end %b expected %0d %0d %0d %0d 001",
                     name, n_celeb, n_go, n_npb, n_ngb, disp_mode, want_celeb, G, want_npb, want_ngb);
        end
    endtask

    task automatic test_celeb_personal();
        run_game("celeb_personal", 16'd300, 16'd200, 16'd500, M_CP, C, 1, 0);
    endtask

    task automatic test_celeb_global();
        run_game("celeb_global", 16'd501, 16'd200, 16'd500, M_CG, C, 1, 1);
    endtask

    task automatic test_no_record();
        run_game("no_record", 16'd500, 16'd500, 16'd500, M_GO, 0, 0, 0);
    endtask

    task automatic test_priority();
        rst = 1'b1; tick(); clear_inputs();
        game_start = 1'b1; tick(); game_start = 1'b0;
        final_score = 16'd50; personal_best = 16'd10; global_best = 16'd90;
        game_start = 1'b1; game_over = 1'b1;
        tick();
        checks++;
        if (disp_mode !== M_CP || new_personal_best !== 1'b1) begin
            errors++;
            $display("FAIL start_over_together: got mode %b npb %b expected 010 1", disp_mode, new_personal_best);
        end
        game_over = 1'b0;
        for (int k = 0; k < C + 3; k++) begin
            game_start = (k < C - 1) ? 1'b1 : 1'b0;
            tick();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL start_in_celeb cyc %0d: got %b expected %b", k, obs, expv);
            end
        end
        game_start = 1'b1;
        tick();
        game_start = 1'b0;
        checks++;
        if (disp_mode !== M_PLAY || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_in_gameover: got mode %b busy %b expected 000 1", disp_mode, busy);
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1; tick(); clear_inputs();
        game_start = 1'b1; tick(); game_start = 1'b0;
        final_score = 16'd900; personal_best = 16'd100; global_best = 16'd800;
        game_over = 1'b1; tick(); game_over = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({disp_mode, fuel_gauge, new_personal_best, new_global_best, busy} !== {3'b001, 10'd0, 3'b000}) begin
            errors++;
            $display("FAIL reset_mid_celeb: got %b expected 0010000000000000", obs);
        end
        // Reset on the very edge that would register a record must drop the strobe.
        game_start = 1'b1; tick(); game_start = 1'b0;
        game_over = 1'b1; rst = 1'b1;
        tick();
        game_over = 1'b0; rst = 1'b0;
        checks++;
        if (obs !== expv || new_personal_best !== 1'b0) begin
            errors++;
            $display("FAIL reset_suppresses_strobe: got %b expected %b", obs, expv);
        end
    endtask

    task automatic test_random();
        rst = 1'b1; tick(); clear_inputs();
        for (int k = 0; k < 600; k++) begin
            rst           = ($urandom_range(0, 99) == 0);
            game_start    = ($urandom_range(0, 9) == 0);
            game_over     = ($urandom_range(0, 5) == 0);
            fuel_level    = 4'($urandom_range(0, 15));
            final_score   = 16'($urandom_range(0, 12));
            personal_best = 16'($urandom_range(0, 8));
            global_best   = personal_best + 16'($urandom_range(0, 4));
            tick();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL random cyc %0d: got %b expected %b", k, obs, expv);
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_fuel();
        test_celeb_personal();
        test_celeb_global();
        test_no_record();
        test_priority();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
